ccip_flow_batch_transmitter: RTL and testbench
==============================================

// Module: ccip_flow_batch_transmitter
// PURPOSE
//  Parametrised CPU-NIC TX path: per-flow payload FIFOs, round-robin batch scheduler, batched
//  eREQ_WRLINE_I on CCI-P c1. Sits between the RPC pipeline and the CCI-P shim.
//  Respects c1 almost-full backpressure. Flushes partial batches after a programmable timeout.
// PARAMETERS
//  NIC_ID            0    instance id, used only in $display traces
//  LMAX_NUM_OF_FLOWS 2    log2 of flow count; MAX_FLOWS = 2**LMAX_NUM_OF_FLOWS
//  LMAX_BATCH        2    log2 of max lines per batch; legal range 0..2 (CCI-P limit of 4 CL)
//  LFIFO_DEPTH       3    log2 of per-flow FIFO depth in lines; must be >= LMAX_BATCH
//  DATA_WIDTH        512  payload bits per line; <=512, zero-extended into sTx_c1.data
//  TIMEOUT_W         16   width of flush_timeout and of the per-flow age counters
// PORTS
//  clk             in   1                  single clock
//  reset_n         in   1                  asynchronous, active-low reset
//  number_of_flows in   LMAX_NUM_OF_FLOWS  index of the highest active flow
//  tx_base_addr    in   t_ccip_clAddr      base CL address of the TX ring
//  l_tx_batch_size in   LMAX_BATCH+1       log2 of lines per batch; clamped to LMAX_BATCH
//  start           in   1                  enables accept and launch
//  flush_timeout   in   TIMEOUT_W          age in cycles before a partial flush; 0 disables
//  sRx_c1TxAlmFull in   1                  c1 almost-full from the shim
//  sTx_c1          out  t_if_ccip_c1_Tx    CCI-P c1 write request, registered
//  rpc_in_ready    out  1                  equals start
//  rpc_in          in   DATA_WIDTH         payload
//  rpc_in_valid    in   1                  payload strobe
//  rpc_flow_id_in  in   LMAX_NUM_OF_FLOWS  target flow
//  pdrop_out       out  1                  1-cycle pulse per dropped payload
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - all FIFOs are emptied; age counters, flow_ptr and beat counters go to 0; state goes to IDLE.
//   - sTx_c1.valid=0, pdrop_out=0 (and all stat counters=0). Applies mid-batch; no partial completion.
//  Push:
//   - accepted when rpc_in_valid & start, flow id <= number_of_flows, and target FIFO not full.
//   - otherwise, if rpc_in_valid, the payload is dropped and pdrop_out pulses 1 cycle later.
//   - push and pop on the same FIFO in the same cycle are legal; occupancy is unchanged.
//   - a push to a full FIFO drops even if a pop occurs that cycle.
//  Age: per-flow counter.
//   - +1 per cycle while that FIFO is non-empty; saturates at all-ones.
//   - cleared when the FIFO is empty or when a batch is launched for that flow.
//  Scheduler FSM:
//   IDLE, at flow_ptr, with B = 2**min(l_tx_batch_size, LMAX_BATCH) and start=1:
//   - occupancy >= B -> FULL batch: N=B, cl_len=log2 B. Go to SEND.
//   - else if flush_timeout!=0, occupancy>0 and age>=flush_timeout -> FLUSH: N=occupancy (<B),
//     sent as N single-line writes (cl_len=eCL_LEN_1, sop=1 each). Go to SEND.
//   - else flow_ptr advances by 1, wrapping from number_of_flows to 0; one flow examined per cycle.
//   SEND: beat k=0..N-1.
//   - a beat pops when sRx_c1TxAlmFull=0; no pop while it is 1.
//   - sTx_c1.valid rises the cycle after the pop; an in-flight beat is always issued.
//   - hdr: req_type=eREQ_WRLINE_I, vc_sel=eVC_VH0, address = tx_base_addr + (flow_ptr<<LMAX_BATCH) + k.
//   - FULL batch: sop=1 on k=0 only. FLUSH: sop=1 on every beat.
//   - after beat N-1: flow_ptr advances (round robin), then IDLE.
//   - start=0 mid-SEND: the current batch completes; no new launch.
//   - l_tx_batch_size or number_of_flows changed mid-SEND: takes effect at the next IDLE decision.
//  Throughput: 1 line/cycle within a batch; at most 1 idle cycle between batches.
// CONFIGURATION
//  TX_STATS_EN defined: adds outputs stat_lines, stat_batches, stat_flushes, stat_drops
//   (32b each, wrap-around, cleared by reset).
//   - stat_lines: +1 per valid line. stat_batches: +1 per FULL launch.
//   - stat_flushes: +1 per FLUSH launch. stat_drops: +1 per pdrop pulse.
//  TX_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.
// TESTING
//  1 l_tx=2, 4 pushes to flow 1, base=0x100 -> 4 valid beats at 0x104..0x107,
//    cl_len=eCL_LEN_4, sop only on the 0x104 beat.
//  2 flows 0..3 each filled to B=2, l_tx=1 -> batches issued in order 0,1,2,3, each 2 beats.
//  3 flush_timeout=20, 3 pushes to flow 2, l_tx=2 -> no output before age 20; then 3 lines,
//    cl_len=eCL_LEN_1, sop=1 on each, addr base+8..10.
//  4 hold sRx_c1TxAlmFull=1 for 10 cycles mid-batch -> at most 1 beat after the assert;
//    the batch resumes intact with no duplicated or lost lines.
//  5 9 pushes to flow 0 (depth 8) with start=1 and alm_full=1 -> 9th push dropped,
//    pdrop_out pulses once (stat_drops=1 with TX_STATS_EN).
//  6 reset_n low during beat 2 of a 4-beat batch -> valid=0 at once, FIFOs empty,
//    no further beats after release.

Source files
------------

// File: rtl/ccip_flow_batch_transmitter.sv
// ccip_flow_batch_transmitter: per-flow payload FIFOs, round-robin batch scheduler and batched
// eREQ_WRLINE_I writes on CCI-P c1. Define TX_STATS_EN to add the stat_* counter outputs.

typedef logic [41:0]  t_ccip_clAddr;
typedef logic [511:0] t_ccip_clData;
typedef logic [15:0]  t_ccip_mdata;

typedef enum logic [1:0] {
   eVC_VA  = 2'h0,
   eVC_VL0 = 2'h1,
   eVC_VH0 = 2'h2,
   eVC_VH1 = 2'h3
} t_ccip_vc;

typedef enum logic [1:0] {
   eCL_LEN_1 = 2'h0,
   eCL_LEN_2 = 2'h1,
   eCL_LEN_4 = 2'h3
} t_ccip_clLen;

typedef enum logic [3:0] {
   eREQ_WRLINE_I = 4'h0,
   eREQ_WRLINE_M = 4'h1,
   eREQ_WRPUSH_I = 4'h2,
   eREQ_WRFENCE  = 4'h4,
   eREQ_INTR     = 4'h6
} t_ccip_c1_req;

typedef struct packed {
   logic [5:0]   rsvd2;
   t_ccip_vc     vc_sel;
   logic         sop;
   logic         rsvd1;
   t_ccip_clLen  cl_len;
   t_ccip_c1_req req_type;
   logic [5:0]   rsvd0;
   t_ccip_clAddr address;
   t_ccip_mdata  mdata;
} t_ccip_c1_ReqMemHdr;

typedef struct packed {
   t_ccip_c1_ReqMemHdr hdr;
   t_ccip_clData       data;
   logic               valid;
} t_if_ccip_c1_Tx;

module ccip_flow_batch_transmitter #(
   parameter int NIC_ID            = 0,
   parameter int LMAX_NUM_OF_FLOWS = 2,
   parameter int LMAX_BATCH        = 2,
   parameter int LFIFO_DEPTH       = 3,
   parameter int DATA_WIDTH        = 512,
   parameter int TIMEOUT_W         = 16
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
   input  t_ccip_clAddr                 tx_base_addr,
   input  logic [LMAX_BATCH:0]          l_tx_batch_size,
   input  logic                         start,
   input  logic [TIMEOUT_W-1:0]         flush_timeout,
   input  logic                         sRx_c1TxAlmFull,
   output t_if_ccip_c1_Tx               sTx_c1,
   output logic                         rpc_in_ready,
   input  logic [DATA_WIDTH-1:0]        rpc_in,
   input  logic                         rpc_in_valid,
   input  logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in,
   output logic                         pdrop_out
`ifdef TX_STATS_EN
   ,
   output logic [31:0]                  stat_lines,
   output logic [31:0]                  stat_batches,
   output logic [31:0]                  stat_flushes,
   output logic [31:0]                  stat_drops
`endif
);

   localparam int MAX_FLOWS = 2 ** LMAX_NUM_OF_FLOWS;
   localparam int DEPTH     = 2 ** LFIFO_DEPTH;
   localparam int CW        = LFIFO_DEPTH + 1;
   localparam int BW        = LMAX_BATCH + 1;

   typedef enum logic {IDLE, SEND} t_state;

   t_state                         state;
   logic [LMAX_NUM_OF_FLOWS-1:0]   flow_ptr;
   logic [LMAX_NUM_OF_FLOWS-1:0]   next_ptr;
   logic [BW-1:0]                  beat;
   logic [BW-1:0]                  n_beats;
   logic                           is_flush;
   t_ccip_clLen                    cl_len_r;

   logic [DATA_WIDTH-1:0]          mem     [MAX_FLOWS][DEPTH];
   logic [LFIFO_DEPTH-1:0]         wr_ptr  [MAX_FLOWS];
   logic [LFIFO_DEPTH-1:0]         rd_ptr  [MAX_FLOWS];
   logic [CW-1:0]                  count   [MAX_FLOWS];
   logic [TIMEOUT_W-1:0]           age     [MAX_FLOWS];

   logic [LMAX_BATCH:0]            l_eff;
   logic [BW-1:0]                  batch_b;
   t_ccip_clLen                    full_len;
   logic [CW-1:0]                  occ;
   logic                           full_go;
   logic                           flush_go;
   logic                           launch;
   logic                           accept;
   logic                           pop;
   logic [MAX_FLOWS-1:0]           push_vec;
   logic [MAX_FLOWS-1:0]           pop_vec;

   always_comb begin
      rpc_in_ready = start;
      l_eff = (l_tx_batch_size > BW'(LMAX_BATCH)) ? BW'(LMAX_BATCH) : l_tx_batch_size;
      batch_b = BW'(1) << l_eff;
      if (l_eff == '0)
         full_len = eCL_LEN_1;
      else if (l_eff == BW'(1))
         full_len = eCL_LEN_2;
      else
         full_len = eCL_LEN_4;
      occ = count[flow_ptr];
      next_ptr = (flow_ptr >= number_of_flows) ? '0 : flow_ptr + 1'b1;
      full_go = occ >= CW'(batch_b);
      flush_go = (flush_timeout != '0) && (occ != '0) && (age[flow_ptr] >= flush_timeout);
      launch = (state == IDLE) && start && (full_go || flush_go);
      accept = rpc_in_valid && start && (rpc_flow_id_in <= number_of_flows) &&
               (count[rpc_flow_id_in] != CW'(DEPTH));
      pop = (state == SEND) && !sRx_c1TxAlmFull;
      push_vec = '0;
      pop_vec = '0;
      for (int unsigned f = 0; f < MAX_FLOWS; f++) begin
         push_vec[f] = accept && (rpc_flow_id_in == LMAX_NUM_OF_FLOWS'(f));
         pop_vec[f]  = pop && (flow_ptr == LMAX_NUM_OF_FLOWS'(f));
      end
   end

   // Payload storage carries no reset; emptiness is tracked by the pointers and counts.
   always_ff @(posedge clk) begin
      if (accept)
         mem[rpc_flow_id_in][wr_ptr[rpc_flow_id_in]] <= rpc_in;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned f = 0; f < MAX_FLOWS; f++) begin
            wr_ptr[f] <= '0;
            rd_ptr[f] <= '0;
            count[f]  <= '0;
            age[f]    <= '0;
         end
      end else begin
         for (int unsigned f = 0; f < MAX_FLOWS; f++) begin
            if (push_vec[f])
               wr_ptr[f] <= wr_ptr[f] + 1'b1;
            if (pop_vec[f])
               rd_ptr[f] <= rd_ptr[f] + 1'b1;
            case ({push_vec[f], pop_vec[f]})
               2'b10:   count[f] <= count[f] + 1'b1;
               2'b01:   count[f] <= count[f] - 1'b1;
               default: count[f] <= count[f];
            endcase
            if (launch && (flow_ptr == LMAX_NUM_OF_FLOWS'(f)))
               age[f] <= '0;
            else if (count[f] == '0)
               age[f] <= '0;
            else if (age[f] != '1)
               age[f] <= age[f] + 1'b1;
         end
      end
   end

   // The write is issued the cycle after its pop, so a popped beat is never held back.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         flow_ptr  <= '0;
         beat      <= '0;
         n_beats   <= '0;
         is_flush  <= 1'b0;
         cl_len_r  <= eCL_LEN_1;
         sTx_c1    <= '0;
         pdrop_out <= 1'b0;
      end else begin
         pdrop_out    <= rpc_in_valid && !accept;
         sTx_c1.valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (full_go) begin
                     state    <= SEND;
                     n_beats  <= batch_b;
                     is_flush <= 1'b0;
                     cl_len_r <= full_len;
                     beat     <= '0;
                  end else if (flush_go) begin
                     state    <= SEND;
                     n_beats  <= BW'(occ);
                     is_flush <= 1'b1;
                     cl_len_r <= eCL_LEN_1;
                     beat     <= '0;
                  end else begin
                     flow_ptr <= next_ptr;
                  end
               end
            end
            SEND: begin
               if (pop) begin
                  sTx_c1.valid            <= 1'b1;
                  sTx_c1.data             <= t_ccip_clData'(mem[flow_ptr][rd_ptr[flow_ptr]]);
                  sTx_c1.hdr.req_type     <= eREQ_WRLINE_I;
                  sTx_c1.hdr.vc_sel       <= eVC_VH0;
                  sTx_c1.hdr.cl_len       <= cl_len_r;
                  sTx_c1.hdr.sop          <= is_flush || (beat == '0);
                  sTx_c1.hdr.mdata        <= 16'(NIC_ID);
                  sTx_c1.hdr.address      <= tx_base_addr + (t_ccip_clAddr'(flow_ptr) << LMAX_BATCH)
                                             + t_ccip_clAddr'(beat);
                  if (beat == n_beats - BW'(1)) begin
                     state    <= IDLE;
                     flow_ptr <= next_ptr;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef TX_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_lines   <= '0;
         stat_batches <= '0;
         stat_flushes <= '0;
         stat_drops   <= '0;
      end else begin
         if (pop)
            stat_lines <= stat_lines + 1'b1;
         if (launch && full_go)
            stat_batches <= stat_batches + 1'b1;
         if (launch && !full_go)
            stat_flushes <= stat_flushes + 1'b1;
         if (rpc_in_valid && !accept)
            stat_drops <= stat_drops + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_ccip_flow_batch_transmitter.sv
// Directed bench for ccip_flow_batch_transmitter: batching, round robin, flush, backpressure,
// drops and mid-batch reset, with hand-computed expectations.
module tb_ccip_flow_batch_transmitter;
   localparam int LF = 2;
   localparam int LB = 2;
   localparam int DW = 512;
   localparam int TW = 16;

   logic                clk = 1'b0;
   logic                reset_n;
   logic [LF-1:0]       number_of_flows;
   t_ccip_clAddr        tx_base_addr;
   logic [LB:0]         l_tx_batch_size;
   logic                start;
   logic [TW-1:0]       flush_timeout;
   logic                sRx_c1TxAlmFull;
   t_if_ccip_c1_Tx      sTx_c1;
   logic                rpc_in_ready;
   logic [DW-1:0]       rpc_in;
   logic                rpc_in_valid;
   logic [LF-1:0]       rpc_flow_id_in;
   logic                pdrop_out;
`ifdef TX_STATS_EN
   logic [31:0]         stat_lines, stat_batches, stat_flushes, stat_drops;
`endif

   ccip_flow_batch_transmitter #(
      .NIC_ID(0), .LMAX_NUM_OF_FLOWS(LF), .LMAX_BATCH(LB), .LFIFO_DEPTH(3),
      .DATA_WIDTH(DW), .TIMEOUT_W(TW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .number_of_flows(number_of_flows),
      .tx_base_addr(tx_base_addr), .l_tx_batch_size(l_tx_batch_size), .start(start),
      .flush_timeout(flush_timeout), .sRx_c1TxAlmFull(sRx_c1TxAlmFull), .sTx_c1(sTx_c1),
      .rpc_in_ready(rpc_in_ready), .rpc_in(rpc_in), .rpc_in_valid(rpc_in_valid),
      .rpc_flow_id_in(rpc_flow_id_in), .pdrop_out(pdrop_out)
`ifdef TX_STATS_EN
      , .stat_lines(stat_lines), .stat_batches(stat_batches),
      .stat_flushes(stat_flushes), .stat_drops(stat_drops)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int drop_seen = 0;
   t_ccip_clAddr  cap_addr[$];
   logic          cap_sop[$];
   logic [1:0]    cap_len[$];
   logic [DW-1:0] cap_data[$];
   int            cap_cyc[$];

   always @(posedge clk) begin
      #1;
      cyc++;
      if (sTx_c1.valid === 1'b1) begin
         cap_addr.push_back(sTx_c1.hdr.address);
         cap_sop.push_back(sTx_c1.hdr.sop);
         cap_len.push_back(sTx_c1.hdr.cl_len);
         cap_data.push_back(sTx_c1.data[DW-1:0]);
         cap_cyc.push_back(cyc);
      end
      if (pdrop_out === 1'b1) drop_seen++;
   end

   task automatic clear_caps();
      cap_addr.delete(); cap_sop.delete(); cap_len.delete(); cap_data.delete(); cap_cyc.delete();
      drop_seen = 0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      start = 1'b0; rpc_in_valid = 1'b0; rpc_in = '0; rpc_flow_id_in = '0;
      sRx_c1TxAlmFull = 1'b0; flush_timeout = '0; number_of_flows = 2'd3;
      tx_base_addr = '0; l_tx_batch_size = 3'd2;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      clear_caps();
   endtask

   task automatic push(input int f, input logic [DW-1:0] d);
      rpc_in_valid = 1'b1;
      rpc_flow_id_in = f[LF-1:0];
      rpc_in = d;
      @(negedge clk);
      rpc_in_valid = 1'b0;
   endtask

   task automatic wait_beats(input int n, input int budget);
      for (int i = 0; i < budget && cap_addr.size() < n; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; rpc_in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (sTx_c1.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", sTx_c1.valid); end
      n_cmp++; if (pdrop_out !== 1'b0) begin n_fail++; $display("FAIL reset_pdrop: got %b want 0", pdrop_out); end
      n_cmp++; if (rpc_in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_lo: got %b want 0", rpc_in_ready); end
      start = 1'b1; #1;
      n_cmp++; if (rpc_in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_hi: got %b want 1", rpc_in_ready); end
      start = 1'b0;
   endtask

   task automatic test_full_batch();
      do_reset();
      tx_base_addr = 42'h100; l_tx_batch_size = 3'd2; start = 1'b1;
      for (int i = 0; i < 4; i++) push(1, DW'(32'hA0 + i));
      wait_beats(4, 40);
      repeat (5) @(negedge clk);
      n_cmp++; if (cap_addr.size() !== 4) begin n_fail++; $display("FAIL full_count: got %0d want 4", cap_addr.size()); end
      for (int k = 0; k < 4 && k < cap_addr.size(); k++) begin
         n_cmp++; if (cap_addr[k] !== 42'h104 + k) begin n_fail++; $display("FAIL full_addr%0d: got %0h want %0h", k, cap_addr[k], 42'h104 + k); end
         n_cmp++; if (cap_sop[k] !== (k == 0)) begin n_fail++; $display("FAIL full_sop%0d: got %b want %b", k, cap_sop[k], (k == 0)); end
         n_cmp++; if (cap_len[k] !== 2'h3) begin n_fail++; $display("FAIL full_len%0d: got %0h want 3", k, cap_len[k]); end
         n_cmp++; if (cap_data[k] !== DW'(32'hA0 + k)) begin n_fail++; $display("FAIL full_data%0d: got %0h want %0h", k, cap_data[k], 32'hA0 + k); end
         if (k > 0) begin
            n_cmp++; if (cap_cyc[k] - cap_cyc[k-1] !== 1) begin n_fail++; $display("FAIL full_gap%0d: got %0d want 1", k, cap_cyc[k] - cap_cyc[k-1]); end
         end
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      tx_base_addr = 42'h200; l_tx_batch_size = 3'd1; start = 1'b1; sRx_c1TxAlmFull = 1'b1;
      push(0, DW'(32'hB0)); push(0, DW'(32'hB1));
      repeat (6) @(negedge clk);
      for (int f = 1; f < 4; f++) begin
         push(f, DW'(32'hB0 + 2*f)); push(f, DW'(32'hB1 + 2*f));
      end
      sRx_c1TxAlmFull = 1'b0;
      wait_beats(8, 60);
      repeat (5) @(negedge clk);
      n_cmp++; if (cap_addr.size() !== 8) begin n_fail++; $display("FAIL rr_count: got %0d want 8", cap_addr.size()); end
      for (int k = 0; k < 8 && k < cap_addr.size(); k++) begin
         n_cmp++; if (cap_addr[k] !== 42'h200 + ((k / 2) * 4) + (k % 2)) begin n_fail++; $display("FAIL rr_addr%0d: got %0h want %0h", k, cap_addr[k], 42'h200 + ((k / 2) * 4) + (k % 2)); end
         n_cmp++; if (cap_sop[k] !== (k % 2 == 0)) begin n_fail++; $display("FAIL rr_sop%0d: got %b", k, cap_sop[k]); end
         n_cmp++; if (cap_len[k] !== 2'h1) begin n_fail++; $display("FAIL rr_len%0d: got %0h want 1", k, cap_len[k]); end
         n_cmp++; if (cap_data[k] !== DW'(32'hB0 + k)) begin n_fail++; $display("FAIL rr_data%0d: got %0h want %0h", k, cap_data[k], 32'hB0 + k); end
         if (k > 0) begin
            n_cmp++; if (cap_cyc[k] - cap_cyc[k-1] > ((k % 2 == 1) ? 1 : 2)) begin n_fail++; $display("FAIL rr_gap%0d: got %0d", k, cap_cyc[k] - cap_cyc[k-1]); end
         end
      end
   endtask

   task automatic test_flush();
      int t0;
      do_reset();
      tx_base_addr = 42'h300; l_tx_batch_size = 3'd2; flush_timeout = 16'd20; start = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 3; i++) push(2, DW'(32'hC0 + i));
      wait_beats(3, 60);
      repeat (5) @(negedge clk);
      n_cmp++; if (cap_addr.size() !== 3) begin n_fail++; $display("FAIL flush_count: got %0d want 3", cap_addr.size()); end
      if (cap_addr.size() > 0) begin
         n_cmp++; if (cap_cyc[0] - t0 < 21) begin n_fail++; $display("FAIL flush_early: got %0d cycles want >=21", cap_cyc[0] - t0); end
      end
      for (int k = 0; k < 3 && k < cap_addr.size(); k++) begin
         n_cmp++; if (cap_addr[k] !== 42'h308 + k) begin n_fail++; $display("FAIL flush_addr%0d: got %0h want %0h", k, cap_addr[k], 42'h308 + k); end
         n_cmp++; if (cap_sop[k] !== 1'b1) begin n_fail++; $display("FAIL flush_sop%0d: got %b want 1", k, cap_sop[k]); end
         n_cmp++; if (cap_len[k] !== 2'h0) begin n_fail++; $display("FAIL flush_len%0d: got %0h want 0", k, cap_len[k]); end
         n_cmp++; if (cap_data[k] !== DW'(32'hC0 + k)) begin n_fail++; $display("FAIL flush_data%0d: got %0h", k, cap_data[k]); end
      end
   endtask

   task automatic test_backpressure();
      int n0;
      do_reset();
      l_tx_batch_size = 3'd2; start = 1'b1;
      for (int i = 0; i < 4; i++) push(0, DW'(32'hD0 + i));
      wait_beats(1, 20);
      sRx_c1TxAlmFull = 1'b1;
      n0 = cap_addr.size();
      repeat (10) @(negedge clk);
      n_cmp++; if (cap_addr.size() > n0 + 1) begin n_fail++; $display("FAIL bp_hold: got %0d beats want <=%0d", cap_addr.size(), n0 + 1); end
      n_cmp++; if (cap_addr.size() >= 4) begin n_fail++; $display("FAIL bp_paused: got %0d beats want <4", cap_addr.size()); end
      sRx_c1TxAlmFull = 1'b0;
      wait_beats(4, 30);
      repeat (5) @(negedge clk);
      n_cmp++; if (cap_addr.size() !== 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", cap_addr.size()); end
      for (int k = 0; k < 4 && k < cap_addr.size(); k++) begin
         n_cmp++; if (cap_data[k] !== DW'(32'hD0 + k)) begin n_fail++; $display("FAIL bp_data%0d: got %0h want %0h", k, cap_data[k], 32'hD0 + k); end
         n_cmp++; if (cap_addr[k] !== 42'(k)) begin n_fail++; $display("FAIL bp_addr%0d: got %0h want %0h", k, cap_addr[k], k); end
         n_cmp++; if (cap_sop[k] !== (k == 0)) begin n_fail++; $display("FAIL bp_sop%0d: got %b", k, cap_sop[k]); end
      end
   endtask

   task automatic test_overflow_drop();
      do_reset();
      l_tx_batch_size = 3'd2; start = 1'b1; sRx_c1TxAlmFull = 1'b1;
      for (int i = 0; i < 9; i++) begin
         push(0, DW'(32'hE0 + i));
         n_cmp++; if (pdrop_out !== (i == 8)) begin n_fail++; $display("FAIL ovf_pdrop%0d: got %b want %b", i, pdrop_out, (i == 8)); end
      end
      repeat (3) @(negedge clk);
      n_cmp++; if (drop_seen !== 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d want 1", drop_seen); end
`ifdef TX_STATS_EN
      n_cmp++; if (stat_drops !== 32'd1) begin n_fail++; $display("FAIL stat_drops: got %0d want 1", stat_drops); end
`endif
      sRx_c1TxAlmFull = 1'b0;
      wait_beats(8, 60);
      repeat (5) @(negedge clk);
      n_cmp++; if (cap_addr.size() !== 8) begin n_fail++; $display("FAIL ovf_count: got %0d want 8", cap_addr.size()); end
      for (int k = 0; k < 8 && k < cap_addr.size(); k++) begin
         n_cmp++; if (cap_data[k] !== DW'(32'hE0 + k)) begin n_fail++; $display("FAIL ovf_data%0d: got %0h want %0h", k, cap_data[k], 32'hE0 + k); end
         n_cmp++; if (cap_addr[k] !== 42'(k % 4)) begin n_fail++; $display("FAIL ovf_addr%0d: got %0h want %0h", k, cap_addr[k], k % 4); end
      end
`ifdef TX_STATS_EN
      n_cmp++; if (stat_batches !== 32'd2) begin n_fail++; $display("FAIL stat_batches: got %0d want 2", stat_batches); end
`endif
   endtask

   task automatic test_drop_rules();
      do_reset();
      number_of_flows = 2'd1; l_tx_batch_size = 3'd0; tx_base_addr = 42'h40; start = 1'b1;
      push(3, DW'(32'hF3));
      n_cmp++; if (pdrop_out !== 1'b1) begin n_fail++; $display("FAIL drop_flowid: got %b want 1", pdrop_out); end
      start = 1'b0;
      push(0, DW'(32'hF0));
      n_cmp++; if (pdrop_out !== 1'b1) begin n_fail++; $display("FAIL drop_nostart: got %b want 1", pdrop_out); end
      start = 1'b1;
      push(1, DW'(32'hF1));
      n_cmp++; if (pdrop_out !== 1'b0) begin n_fail++; $display("FAIL accept_ok: got %b want 0", pdrop_out); end
      repeat (15) @(negedge clk);
      n_cmp++; if (cap_addr.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", cap_addr.size()); end
      if (cap_addr.size() > 0) begin
         n_cmp++; if (cap_addr[0] !== 42'h44) begin n_fail++; $display("FAIL single_addr: got %0h want 44", cap_addr[0]); end
         n_cmp++; if (cap_data[0] !== DW'(32'hF1)) begin n_fail++; $display("FAIL single_data: got %0h want f1", cap_data[0]); end
         n_cmp++; if ({cap_sop[0], cap_len[0]} !== 3'b100) begin n_fail++; $display("FAIL single_hdr: got %b want 100", {cap_sop[0], cap_len[0]}); end
      end
   endtask

   task automatic test_reset_mid_batch();
      do_reset();
      tx_base_addr = 42'h100; l_tx_batch_size = 3'd2; start = 1'b1;
      for (int i = 0; i < 4; i++) push(1, DW'(32'h90 + i));
      wait_beats(2, 40);
      reset_n = 1'b0;
      #1;
      n_cmp++; if (sTx_c1.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", sTx_c1.valid); end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      clear_caps();
      repeat (20) @(negedge clk);
      n_cmp++; if (cap_addr.size() !== 0) begin n_fail++; $display("FAIL rst_nobeats: got %0d want 0", cap_addr.size()); end
      l_tx_batch_size = 3'd3;
      for (int i = 0; i < 4; i++) push(1, DW'(32'h55 + i));
      wait_beats(4, 40);
      repeat (5) @(negedge clk);
      n_cmp++; if (cap_addr.size() !== 4) begin n_fail++; $display("FAIL rst_refill: got %0d want 4", cap_addr.size()); end
      for (int k = 0; k < 4 && k < cap_addr.size(); k++) begin
         n_cmp++; if (cap_data[k] !== DW'(32'h55 + k)) begin n_fail++; $display("FAIL rst_data%0d: got %0h want %0h", k, cap_data[k], 32'h55 + k); end
         n_cmp++; if (cap_len[k] !== 2'h3) begin n_fail++; $display("FAIL clamp_len%0d: got %0h want 3", k, cap_len[k]); end
         n_cmp++; if (cap_addr[k] !== 42'h104 + k) begin n_fail++; $display("FAIL rst_addr%0d: got %0h", k, cap_addr[k]); end
      end
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; rpc_in_valid = 1'b0; rpc_in = '0; rpc_flow_id_in = '0;
      sRx_c1TxAlmFull = 1'b0; flush_timeout = '0; number_of_flows = 2'd3;
      tx_base_addr = '0; l_tx_batch_size = 3'd2;
      test_reset();
      test_full_batch();
      test_round_robin();
      test_flush();
      test_backpressure();
      test_overflow_drop();
      test_drop_rules();
      test_reset_mid_batch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
